// File: rtl/reg_2_mem.sv
// 4-bit register-file / data-memory datapath executing one 10-bit instruction per clock.
// Define REG2MEM_MEM_RESET_EN to make reset also clear the data memory.
module reg_2_mem (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] instruction,
  output logic [3:0] res
);

  typedef enum logic [1:0] {
    OP_STORE_DATA    = 2'b00,
    OP_MOVE_TO_MEM   = 2'b01,
    OP_MOVE_FROM_MEM = 2'b10,
    OP_LOAD_DATA     = 2'b11
  } opcode_t;

  opcode_t    op;
  logic [3:0] fld;
  logic [3:0] addr;

  logic [3:0] regs [16];
  logic [3:0] mem  [16];

  assign op   = opcode_t'(instruction[9:8]);
  assign fld  = instruction[7:4];
  assign addr = instruction[3:0];

  // Register file and result register; both are cleared by reset.
  // NOTE: non-blocking assignments here make every read see pre-edge state, so a
  // read of an entry written on the same edge returns the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      if (op == OP_MOVE_FROM_MEM) regs[fld] <= mem[addr];
      if (op == OP_LOAD_DATA)     res       <= mem[addr];
    end
  end

  // Data memory; reset clears it only in the macro build.
  // NOTE: leaving memory out of reset lets it map onto plain RAM; reset then only
  // blocks writes for that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef REG2MEM_MEM_RESET_EN
      for (int i = 0; i < 16; i++) mem[i] <= '0;
`else
      ;
`endif
    end else begin
      case (op)
        OP_STORE_DATA:  mem[addr] <= fld;
        OP_MOVE_TO_MEM: mem[addr] <= regs[fld];
        default:        ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_2_mem.sv
// Directed self-checking bench for reg_2_mem; expected values are hand-computed
// and observed through res (internal state is read back via MOVE_TO_MEM + LOAD_DATA).
module tb_reg_2_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] instruction;
  logic [3:0] res;

  int n_cmp  = 0;
  int n_fail = 0;

  reg_2_mem dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .res         (res)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] ins(input logic [1:0] op, input logic [3:0] f,
                                     input logic [3:0] a);
    return {op, f, a};
  endfunction

  // Apply one instruction for one rising edge, then sample 1 time unit later.
  task automatic step(input logic [9:0] i);
    instruction = i;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    instruction = ins(2'b11, 4'd0, 4'd3);
    @(posedge clk);
    #1;
    check("reset_res", res, 4'd0);
    rst = 1'b0;

`ifdef REG2MEM_MEM_RESET_EN
    step(ins(2'b11, 4'd0, 4'd3));
    check("load_after_mem_reset", res, 4'd0);
`endif

    step(ins(2'b00, 4'd10, 4'd5));          // M[5]=10
    check("store_res_hold", res, 4'd0);
    step(ins(2'b10, 4'd4, 4'd5));           // R[4]=10
    check("move_from_res_hold", res, 4'd0);
    step(ins(2'b01, 4'd4, 4'd11));          // M[11]=10
    check("move_to_res_hold", res, 4'd0);
    step(ins(2'b11, 4'd0, 4'd11));
    check("load_m11", res, 4'd10);
    step(ins(2'b00, 4'd7, 4'd11));          // M[11]=7
    check("res_hold_over_store", res, 4'd10);
    step(ins(2'b11, 4'd0, 4'd11));
    check("load_m11_new", res, 4'd7);

    // Boundary indices 0 and 15 for memory and register file.
    step(ins(2'b00, 4'd15, 4'd0));          // M[0]=15
    step(ins(2'b00, 4'd3, 4'd15));          // M[15]=3
    step(ins(2'b11, 4'd0, 4'd0));
    check("load_m0", res, 4'd15);
    step(ins(2'b11, 4'd0, 4'd15));
    check("load_m15", res, 4'd3);
    step(ins(2'b10, 4'd15, 4'd0));          // R[15]=15
    step(ins(2'b10, 4'd0, 4'd15));          // R[0]=3
    step(ins(2'b01, 4'd15, 4'd1));          // M[1]=R[15]
    check("res_hold_over_moves", res, 4'd3);
    step(ins(2'b11, 4'd0, 4'd1));
    check("r15_via_m1", res, 4'd15);
    step(ins(2'b01, 4'd0, 4'd2));           // M[2]=R[0]
    step(ins(2'b11, 4'd0, 4'd2));
    check("r0_via_m2", res, 4'd3);

    // Back-to-back dependency and R[4] untouched by other traffic.
    step(ins(2'b00, 4'd9, 4'd6));
    step(ins(2'b11, 4'd0, 4'd6));
    check("store_then_load", res, 4'd9);
    step(ins(2'b01, 4'd4, 4'd3));
    step(ins(2'b11, 4'd0, 4'd3));
    check("r4_retained", res, 4'd10);

    // Holding an instruction for several cycles is idempotent.
    step(ins(2'b00, 4'd12, 4'd7));
    step(ins(2'b00, 4'd12, 4'd7));
    step(ins(2'b00, 4'd12, 4'd7));
    step(ins(2'b11, 4'd0, 4'd7));
    step(ins(2'b11, 4'd0, 4'd7));
    check("held_load", res, 4'd12);
    step(ins(2'b11, 4'd0, 4'd5));
    check("load_m5", res, 4'd10);

    // Reset mid-sequence dominates a LOAD of a nonzero word.
    rst = 1'b1;
    step(ins(2'b11, 4'd0, 4'd11));
    check("reset_mid_res", res, 4'd0);
    rst = 1'b0;
    step(ins(2'b01, 4'd4, 4'd12));
    step(ins(2'b11, 4'd0, 4'd12));
    check("r4_after_reset", res, 4'd0);
    step(ins(2'b01, 4'd15, 4'd13));
    step(ins(2'b11, 4'd0, 4'd13));
    check("r15_after_reset", res, 4'd0);
    step(ins(2'b11, 4'd0, 4'd11));
`ifdef REG2MEM_MEM_RESET_EN
    check("m11_after_reset", res, 4'd0);
`else
    check("m11_after_reset", res, 4'd7);
`endif
    step(ins(2'b11, 4'd0, 4'd0));
`ifdef REG2MEM_MEM_RESET_EN
    check("m0_after_reset", res, 4'd0);
`else
    check("m0_after_reset", res, 4'd15);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
